// File: rtl/ksa_pkg.sv
// ksa_pkg -- shared definitions for the RC4 KSA/PRGA blocks.
// Contents:
//   MSG_LEN_DEFAULT : default number of message bytes decrypted per run
//   prga_state_t    : PRGA controller states (one state per memory access step)
package ksa_pkg;

    localparam int MSG_LEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        READ_SI   = 4'd1,
        LATCH_SI  = 4'd2,
        READ_SJ   = 4'd3,
        LATCH_SJ  = 4'd4,
        WRITE_SI  = 4'd5,
        WRITE_SJ  = 4'd6,
        READ_F    = 4'd7,
        LATCH_F   = 4'd8,
        WRITE_DEC = 4'd9,
        NEXT      = 4'd10,
        DONE      = 4'd11
    } prga_state_t;

endpackage

// File: rtl/prga_decrypt.sv
// prga_decrypt -- RC4 pseudo-random generation and XOR decryption.
// Walks MSG_LEN bytes: i=i+1, j=j+s[i], swap s[i]/s[j], dec[k]=s[s[i]+s[j]]^enc[k].
// Each byte takes ten cycles; one single-port S RAM access per step.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start_flag          : level, S array is ready (KSA finished)
//   done_flag           : high while the whole message has been written
//   s_address/s_data/s_wren/s_q       : S RAM port (s_q one cycle after address)
//   rom_address/rom_q                 : encrypted-message ROM (address = k)
//   dec_address/dec_data/dec_wren     : decrypted-message RAM write port
// All outputs are flops loaded from the next-state decode, so no memory read
// data reaches an address output combinationally.
module prga_decrypt
    import ksa_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_flag,
    output logic       done_flag,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    output logic       s_wren,
    input  logic [7:0] s_q,
    output logic [7:0] rom_address,
    input  logic [7:0] rom_q,
    output logic [7:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_wren
);

    localparam logic [8:0] LAST_K = 9'(MSG_LEN - 1);

    prga_state_t state_r, state_s;
    logic [7:0]  i_r, i_s;
    logic [7:0]  j_r, j_s;
    logic [8:0]  k_r, k_s;
    logic [7:0]  si_r, si_s;
    logic [7:0]  sj_r, sj_s;
    logic [7:0]  f_r, f_s;

    logic [7:0]  s_address_r, s_address_s;
    logic [7:0]  s_data_r, s_data_s;
    logic        s_wren_r, s_wren_s;
    logic [7:0]  rom_address_r, rom_address_s;
    logic [7:0]  dec_address_r, dec_address_s;
    logic [7:0]  dec_data_r, dec_data_s;
    logic        dec_wren_r, dec_wren_s;
    logic        done_flag_r, done_flag_s;

    // Next-state and datapath register update logic.
    always_comb begin
        state_s = state_r;
        i_s     = i_r;
        j_s     = j_r;
        k_s     = k_r;
        si_s    = si_r;
        sj_s    = sj_r;
        f_s     = f_r;
        case (state_r)
            IDLE: begin
                if (start_flag) begin
                    i_s     = 8'd1;
                    j_s     = 8'd0;
                    k_s     = 9'd0;
                    state_s = READ_SI;
                end else begin
                    state_s = IDLE;
                end
            end
            READ_SI:  state_s = LATCH_SI;
            LATCH_SI: begin
                si_s    = s_q;
                j_s     = j_r + s_q;
                state_s = READ_SJ;
            end
            READ_SJ:  state_s = LATCH_SJ;
            LATCH_SJ: begin
                sj_s    = s_q;
                state_s = WRITE_SI;
            end
            WRITE_SI: state_s = WRITE_SJ;
            WRITE_SJ: state_s = READ_F;
            READ_F:   state_s = LATCH_F;
            LATCH_F: begin
                f_s     = s_q;
                state_s = WRITE_DEC;
            end
            WRITE_DEC: state_s = NEXT;
            NEXT: begin
                if (k_r == LAST_K) begin
                    state_s = DONE;
                end else begin
                    k_s     = k_r + 9'd1;
                    i_s     = i_r + 8'd1;
                    state_s = READ_SI;
                end
            end
            DONE: begin
                if (start_flag) begin
                    state_s = DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode for the state being entered; loaded into output flops.
    // dec_data uses rom_q while in LATCH_F: k has been stable since the
    // previous NEXT, so the ROM word for this byte is already valid.
    always_comb begin
        s_address_s   = 8'd0;
        s_data_s      = 8'd0;
        s_wren_s      = 1'b0;
        rom_address_s = k_s[7:0];
        dec_address_s = 8'd0;
        dec_data_s    = 8'd0;
        dec_wren_s    = 1'b0;
        done_flag_s   = 1'b0;
        case (state_s)
            READ_SI: s_address_s = i_s;
            READ_SJ: s_address_s = j_s;
            WRITE_SI: begin
                s_address_s = i_s;
                s_data_s    = sj_s;
                s_wren_s    = 1'b1;
            end
            WRITE_SJ: begin
                s_address_s = j_s;
                s_data_s    = si_s;
                s_wren_s    = 1'b1;
            end
            READ_F: s_address_s = si_s + sj_s;
            WRITE_DEC: begin
                dec_address_s = k_s[7:0];
                dec_data_s    = f_s ^ rom_q;
                dec_wren_s    = 1'b1;
            end
            DONE: done_flag_s = 1'b1;
            default: begin
                s_address_s = 8'd0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            i_r           <= 8'd0;
            j_r           <= 8'd0;
            k_r           <= 9'd0;
            si_r          <= 8'd0;
            sj_r          <= 8'd0;
            f_r           <= 8'd0;
            s_address_r   <= 8'd0;
            s_data_r      <= 8'd0;
            s_wren_r      <= 1'b0;
            rom_address_r <= 8'd0;
            dec_address_r <= 8'd0;
            dec_data_r    <= 8'd0;
            dec_wren_r    <= 1'b0;
            done_flag_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            i_r           <= i_s;
            j_r           <= j_s;
            k_r           <= k_s;
            si_r          <= si_s;
            sj_r          <= sj_s;
            f_r           <= f_s;
            s_address_r   <= s_address_s;
            s_data_r      <= s_data_s;
            s_wren_r      <= s_wren_s;
            rom_address_r <= rom_address_s;
            dec_address_r <= dec_address_s;
            dec_data_r    <= dec_data_s;
            dec_wren_r    <= dec_wren_s;
            done_flag_r   <= done_flag_s;
        end
    end

    assign done_flag   = done_flag_r;
    assign s_address   = s_address_r;
    assign s_data      = s_data_r;
    assign s_wren      = s_wren_r;
    assign rom_address = rom_address_r;
    assign dec_address = dec_address_r;
    assign dec_data    = dec_data_r;
    assign dec_wren    = dec_wren_r;

endmodule

// File: tb/tb_prga_decrypt.sv
// tb_prga_decrypt -- directed self-checking bench for prga_decrypt.
// Three instances (MSG_LEN 4, 256, 32) each with their own S RAM, ROM and
// decrypted RAM models.
module tb_prga_decrypt;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_flag [3];
    logic       done_flag [3];
    logic [7:0] s_address [3];
    logic [7:0] s_data [3];
    logic       s_wren [3];
    logic [7:0] s_q [3];
    logic [7:0] rom_address [3];
    logic [7:0] rom_q [3];
    logic [7:0] dec_address [3];
    logic [7:0] dec_data [3];
    logic       dec_wren [3];

    logic       load [3];
    logic [7:0] s_img [3][256];
    logic [7:0] enc_mem [3][256];
    logic [7:0] s_mem [3][256];
    logic [7:0] dec_mem [3][256];
    int         dec_cnt [3];
    int         overlap_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prga_decrypt #(.MSG_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_flag(start_flag[0]), .done_flag(done_flag[0]),
        .s_address(s_address[0]), .s_data(s_data[0]), .s_wren(s_wren[0]), .s_q(s_q[0]),
        .rom_address(rom_address[0]), .rom_q(rom_q[0]),
        .dec_address(dec_address[0]), .dec_data(dec_data[0]), .dec_wren(dec_wren[0])
    );

    prga_decrypt #(.MSG_LEN(256)) u_dut256 (
        .clk(clk), .rst(rst), .start_flag(start_flag[1]), .done_flag(done_flag[1]),
        .s_address(s_address[1]), .s_data(s_data[1]), .s_wren(s_wren[1]), .s_q(s_q[1]),
        .rom_address(rom_address[1]), .rom_q(rom_q[1]),
        .dec_address(dec_address[1]), .dec_data(dec_data[1]), .dec_wren(dec_wren[1])
    );

    prga_decrypt #(.MSG_LEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .start_flag(start_flag[2]), .done_flag(done_flag[2]),
        .s_address(s_address[2]), .s_data(s_data[2]), .s_wren(s_wren[2]), .s_q(s_q[2]),
        .rom_address(rom_address[2]), .rom_q(rom_q[2]),
        .dec_address(dec_address[2]), .dec_data(dec_data[2]), .dec_wren(dec_wren[2])
    );

    // Memory models: synchronous-read S RAM, ROM and decrypted RAM per instance.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (load[g]) begin
                for (int a = 0; a < 256; a++) begin
                    s_mem[g][a]   <= s_img[g][a];
                    dec_mem[g][a] <= 8'hA5;
                end
                dec_cnt[g] <= 0;
            end else begin
                if (s_wren[g]) s_mem[g][s_address[g]] <= s_data[g];
                if (dec_wren[g]) begin
                    dec_mem[g][dec_address[g]] <= dec_data[g];
                    dec_cnt[g] <= dec_cnt[g] + 1;
                end
            end
            if (s_wren[g] && dec_wren[g]) overlap_cnt <= overlap_cnt + 1;
            s_q[g]   <= s_mem[g][s_address[g]];
            rom_q[g] <= enc_mem[g][rom_address[g]];
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_s(input int g);
        @(negedge clk) load[g] = 1'b1;
        @(negedge clk) load[g] = 1'b0;
    endtask

    // Start instance g and count edges after the start-sampling edge until done.
    // With pulse set, start_flag is dropped for a few cycles during byte 2.
    task automatic run(input int g, input bit pulse, output int cycles);
        @(negedge clk) start_flag[g] = 1'b1;
        @(posedge clk); #1;
        cycles = 0;
        while (!done_flag[g] && cycles < 5000) begin
            @(posedge clk); #1;
            cycles++;
            if (pulse && cycles == 13) start_flag[g] = 1'b0;
            if (pulse && cycles == 16) start_flag[g] = 1'b1;
        end
    endtask

    task automatic stop(input int g);
        @(negedge clk) start_flag[g] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_identity(input int g);
        for (int a = 0; a < 256; a++) s_img[g][a] = 8'(a);
    endtask

    int cyc;
    int bad;
    logic [7:0] rs [256];
    logic [7:0] key [3];
    logic [7:0] mi, mj, tmp;
    logic [7:0] exp_dec [32];
    logic [7:0] exp4_00 [4];
    logic [7:0] exp4_ff [4];

    initial begin
        rst = 1'b1;
        overlap_cnt = 0;
        for (int g = 0; g < 3; g++) begin
            start_flag[g] = 1'b0;
            load[g] = 1'b0;
            for (int a = 0; a < 256; a++) enc_mem[g][a] = 8'h00;
        end
        exp4_00 = '{8'h02, 8'h05, 8'h07, 8'h0D};
        exp4_ff = '{8'hFD, 8'hFA, 8'hF8, 8'hF2};
        repeat (3) @(posedge clk);
        #1;
        check_val("reset s_address", int'(s_address[0]), 0);
        check_val("reset s_data", int'(s_data[0]), 0);
        check_val("reset s_wren", int'(s_wren[0]), 0);
        check_val("reset rom_address", int'(rom_address[0]), 0);
        check_val("reset dec_wren", int'(dec_wren[0]), 0);
        check_val("reset dec_data", int'(dec_data[0]), 0);
        check_val("reset done_flag", int'(done_flag[0]), 0);
        @(negedge clk) rst = 1'b0;

        // Identity S, enc 0x00, four bytes.
        set_identity(0);
        load_s(0);
        run(0, 1'b0, cyc);
        check_val("id00 done cycles", cyc, 40);
        for (int k = 0; k < 4; k++)
            check_val($sformatf("id00 dec[%0d]", k), int'(dec_mem[0][k]), int'(exp4_00[k]));
        check_val("id00 dec writes", dec_cnt[0], 4);
        check_val("id00 s[1]", int'(s_mem[0][1]), 1);
        check_val("id00 s[2]", int'(s_mem[0][2]), 3);
        check_val("id00 s[3]", int'(s_mem[0][3]), 5);
        check_val("id00 s[4]", int'(s_mem[0][4]), 9);
        check_val("id00 s[5]", int'(s_mem[0][5]), 2);
        check_val("id00 s[9]", int'(s_mem[0][9]), 4);
        stop(0);
        check_val("id00 done drop", int'(done_flag[0]), 0);

        // Identity S, enc 0xFF, start pulsed low during byte 2, held in DONE.
        for (int a = 0; a < 256; a++) enc_mem[0][a] = 8'hFF;
        set_identity(0);
        load_s(0);
        run(0, 1'b1, cyc);
        check_val("idff done cycles", cyc, 40);
        for (int k = 0; k < 4; k++)
            check_val($sformatf("idff dec[%0d]", k), int'(dec_mem[0][k]), int'(exp4_ff[k]));
        repeat (3) @(posedge clk);
        #1;
        check_val("idff done held", int'(done_flag[0]), 1);
        check_val("idff wren in done", int'(s_wren[0]) + int'(dec_wren[0]), 0);
        stop(0);
        check_val("idff done drop", int'(done_flag[0]), 0);

        // Reset in the middle of byte 2, then a fresh full run.
        set_identity(0);
        load_s(0);
        @(negedge clk) start_flag[0] = 1'b1;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrst rom_address async", int'(rom_address[0]), 0);
        @(posedge clk); #1;
        check_val("midrst s_wren", int'(s_wren[0]), 0);
        check_val("midrst dec_wren", int'(dec_wren[0]), 0);
        check_val("midrst done_flag", int'(done_flag[0]), 0);
        check_val("midrst s_address", int'(s_address[0]), 0);
        check_val("midrst dec_address", int'(dec_address[0]), 0);
        @(negedge clk) begin
            start_flag[0] = 1'b0;
            rst = 1'b0;
        end
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (s_wren[0] || dec_wren[0] || s_address[0] != 8'd0) bad++;
        end
        check_val("midrst idle quiet", bad, 0);
        set_identity(0);
        load_s(0);
        run(0, 1'b0, cyc);
        check_val("midrst rerun cycles", cyc, 40);
        for (int k = 0; k < 4; k++)
            check_val($sformatf("midrst dec[%0d]", k), int'(dec_mem[0][k]), int'(exp4_ff[k]));
        stop(0);

        // S all 0xFF, enc 0x00, 256 bytes: i wraps, every byte 0xFF.
        for (int a = 0; a < 256; a++) s_img[1][a] = 8'hFF;
        load_s(1);
        run(1, 1'b0, cyc);
        check_val("ff256 done cycles", cyc, 2560);
        bad = 0;
        for (int k = 0; k < 256; k++) if (dec_mem[1][k] != 8'hFF) bad++;
        check_val("ff256 bad bytes", bad, 0);
        check_val("ff256 dec writes", dec_cnt[1], 256);
        stop(1);

        // Software RC4 with key 00 02 49: KSA, then PRGA keystream.
        key = '{8'h00, 8'h02, 8'h49};
        for (int a = 0; a < 256; a++) rs[a] = 8'(a);
        mj = 8'd0;
        for (int a = 0; a < 256; a++) begin
            mj = mj + rs[a] + key[a % 3];
            tmp = rs[a]; rs[a] = rs[mj]; rs[mj] = tmp;
        end
        for (int a = 0; a < 256; a++) s_img[2][a] = rs[a];
        for (int k = 0; k < 32; k++) enc_mem[2][k] = 8'(k * 37 + 11);
        mi = 8'd0;
        mj = 8'd0;
        for (int k = 0; k < 32; k++) begin
            mi = mi + 8'd1;
            mj = mj + rs[mi];
            tmp = rs[mi]; rs[mi] = rs[mj]; rs[mj] = tmp;
            exp_dec[k] = rs[8'(rs[mi] + rs[mj])] ^ enc_mem[2][k];
        end
        load_s(2);
        run(2, 1'b0, cyc);
        check_val("rc4 done cycles", cyc, 320);
        for (int k = 0; k < 32; k++)
            check_val($sformatf("rc4 dec[%0d]", k), int'(dec_mem[2][k]), int'(exp_dec[k]));
        stop(2);

        check_val("write overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prga_decrypt.md
PRGA_DECRYPT -- requirements
Module: prga_decrypt

Interface
REQ-001 Parameter: MSG_LEN, default 32, number of message bytes processed (1..256).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_flag  input  1  level; high = S array ready (KSA complete).
REQ-005 done_flag  output  1  high while all MSG_LEN bytes are written.
REQ-006 s_address  output  8  S memory address.
REQ-007 s_data  output  8  S memory write data.
REQ-008 s_wren  output  1  S memory write enable.
REQ-009 s_q  input  8  S memory read data; valid the cycle after s_address is driven.
REQ-010 rom_address  output  8  encrypted-message ROM address (= k).
REQ-011 rom_q  input  8  ROM data, one-cycle read latency.
REQ-012 dec_address  output  8  decrypted RAM address.
REQ-013 dec_data  output  8  decrypted RAM write data.
REQ-014 dec_wren  output  1  decrypted RAM write enable.

Function
REQ-015 The block SHALL implement the RC4 PRGA: for k = 0..MSG_LEN-1: i=i+1; j=j+s[i]; swap s[i],s[j]; dec[k] = s[s[i]+s[j]] XOR enc[k].
REQ-016 All index and sum arithmetic SHALL be 8-bit, modulo 256; k counter 9-bit.
REQ-017 States: IDLE, READ_SI, LATCH_SI, READ_SJ, LATCH_SJ, WRITE_SI, WRITE_SJ, READ_F, LATCH_F, WRITE_DEC, NEXT, DONE.
REQ-018 IDLE: outputs quiescent; start_flag high -> i<=1, j<=0, k<=0, go READ_SI.
REQ-019 READ_SI: s_address=i. LATCH_SI: si<=s_q, j<=j+s_q.
REQ-020 READ_SJ: s_address=j. LATCH_SJ: sj<=s_q.
REQ-021 WRITE_SI: s_address=i, s_data=sj, s_wren=1. WRITE_SJ: s_address=j, s_data=si, s_wren=1.
REQ-022 READ_F: s_address=si+sj. LATCH_F: f<=s_q.
REQ-023 WRITE_DEC: dec_address=k, dec_data=f XOR rom_q, dec_wren=1.
REQ-024 NEXT: if k==MSG_LEN-1 go DONE, else k<=k+1, i<=i+1, go READ_SI.
REQ-025 rom_address SHALL equal k[7:0] continuously, so rom_q is stable in WRITE_DEC.
REQ-026 Each byte SHALL take exactly 10 cycles; done_flag rises 10*MSG_LEN cycles after the edge sampling start_flag high in IDLE.
REQ-027 i==j: both writes SHALL occur; S content unchanged at that index.
REQ-028 s_wren and dec_wren SHALL be high only in their write states, never simultaneously with a read state.
REQ-029 start_flag deassertion during processing SHALL be ignored.
REQ-030 DONE: done_flag=1, all wren=0; start_flag low -> IDLE (done_flag drops next cycle); start_flag high -> stay.
REQ-031 All outputs SHALL be registered or decoded from state only (Moore); no combinational path from s_q/rom_q to address outputs.

Reset
REQ-032 rst high SHALL force IDLE immediately, regardless of state, including mid-swap.
REQ-033 Reset values: all addresses 0, data outputs 0, s_wren=0, dec_wren=0, done_flag=0, i=j=k=si=sj=f=0.
REQ-034 After rst release the block SHALL wait in IDLE for start_flag; a partial run is not resumed.

Structure
REQ-035 State enum and default MSG_LEN SHALL live in shared package ksa_pkg.
REQ-036 No sub-module; single FSM plus datapath registers; memories instantiated by the top level.

Verification
REQ-037 Reset: assert rst mid-run -> next cycle all wren=0, done_flag=0, addresses 0, state IDLE.
REQ-038 S identity (s[x]=x), enc all 0x00, MSG_LEN=4 -> dec = 02,05,07,0D; done_flag high 40 cycles after start; s[1]=1 (i==j), s[2]=3, s[3]=5, s[4]=9, s[5]=2, s[9]=4.
REQ-039 Same S, enc all 0xFF, MSG_LEN=4 -> dec = FD,FA,F8,F2.
REQ-040 S all 0xFF, enc 0x00, MSG_LEN=256 -> every dec byte 0xFF; i wraps 255->0 without error; done after 2560 cycles.
REQ-041 start_flag pulsed low during byte 2 -> run continues unchanged; start held high in DONE -> done_flag stays 1; drop start -> done_flag 0 next cycle.
REQ-042 Compare full run against software RC4 model with key 0x000249 after init+KSA -> all 32 dec bytes match.
